// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Memory-side responder for the RV32 core's data load/store
//               port. Accepts one word-aligned request at a time, commits
//               byte-lane stores into a word array, returns the full word for
//               loads, and flags illegal byte enables / out-of-range
//               addresses. Every response appears LATENCY cycles after
//               acceptance and is held until the core takes it.
// Ports       : clk, rst (async, active-high)
//               req_valid/req_ready/req_we/req_addr/req_wdata/req_be
//                   request channel (sampled only at acceptance)
//               resp_valid/resp_ready/resp_rdata/resp_err
//                   response channel (held stable until handshake)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         c_idx_w    = $clog2(DEPTH_WORDS);
    // WAIT spends LATENCY-1 cycles: the counter runs LATENCY-2 .. 0.
    localparam logic [3:0] c_cnt_init = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               r_state;
    logic [3:0]           r_cnt;
    logic                 r_req_ready;
    logic                 r_resp_valid;
    logic [31:0]          r_resp_rdata;
    logic                 r_resp_err;
    logic [31:0]          r_mem [DEPTH_WORDS];

    logic [32:0]          w_diff;
    logic [c_idx_w-1:0]   w_index;
    logic                 w_in_range;
    logic                 w_be_ok;
    logic                 w_err;
    logic                 w_accept;
    logic                 w_unused;

    // 33-bit subtraction: bit 32 is the borrow, set when req_addr is below
    // BASE_ADDR. Checking that everything above the index field is zero
    // therefore rejects both below-base and beyond-end addresses at once.
    assign w_diff     = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    assign w_index    = w_diff[c_idx_w+1:2];
    assign w_in_range = (w_diff[32:c_idx_w+2] == '0);
    assign w_unused   = &{1'b0, w_diff[1:0]};

    // Only naturally aligned byte, halfword and word accesses are legal.
    always_comb begin
        w_be_ok = 1'b0;
        case (req_be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: w_be_ok = 1'b1;
            default:                   w_be_ok = 1'b0;
        endcase
    end

    assign w_err    = !w_be_ok || !w_in_range;
    assign w_accept = req_valid && r_req_ready;

    // Storage is not reset. r_req_ready is held low by reset, so no write
    // can be accepted while rst is asserted.
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be[i]) begin
                    r_mem[w_index][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready  <= 1'b0;
                        r_resp_err   <= w_err;
                        // Load data is captured now; later stores cannot
                        // reach it because only one request is in flight.
                        r_resp_rdata <= (!w_err && !req_we) ? r_mem[w_index] : 32'd0;
                        if (LATENCY == 1) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= c_cnt_init;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_rdata <= 32'd0;
                        r_resp_err   <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. A main instance
//               (LATENCY=2) runs directed scenarios and a randomized phase
//               against a word/byte-lane reference model; two auxiliary
//               instances (LATENCY=1 and LATENCY=7 with a non-zero base)
//               cover latency and address-window boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int          c_main_lat   = 2;
    localparam int          c_main_depth = 1024;
    localparam logic [31:0] c_main_base  = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        resp_ready = 1'b1;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        a1_req_valid = 1'b0, a7_req_valid = 1'b0;
    logic        aux_resp_ready = 1'b1;
    logic        a1_req_ready, a1_resp_valid, a1_resp_err;
    logic        a7_req_ready, a7_resp_valid, a7_resp_err;
    logic [31:0] a1_resp_rdata, a7_resp_rdata;

    int          n_checks = 0;
    int          n_err    = 0;

    logic [31:0] model_mem [c_main_depth];
    logic [31:0] exp_rdata;
    logic        exp_err;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(c_main_depth), .LATENCY(c_main_lat), .BASE_ADDR(c_main_base)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1), .BASE_ADDR(32'h0)) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(a1_req_valid), .req_ready(a1_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(a1_resp_valid), .resp_ready(aux_resp_ready),
        .resp_rdata(a1_resp_rdata), .resp_err(a1_resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(7), .BASE_ADDR(32'h100)) u_lat7 (
        .clk(clk), .rst(rst), .req_valid(a7_req_valid), .req_ready(a7_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(a7_resp_valid), .resp_ready(aux_resp_ready),
        .resp_rdata(a7_resp_rdata), .resp_err(a7_resp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit be_legal(input logic [3:0] be);
        return be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    endfunction

    // Reference model: decide legality from the address window and enable
    // pattern, apply stores lane by lane, predict the response word.
    task automatic model_apply(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
        longint off;
        int     idx;
        off       = longint'(addr) - longint'(c_main_base);
        exp_err   = !be_legal(be) || (off < 0) || ((off >>> 2) >= c_main_depth);
        exp_rdata = 32'd0;
        if (!exp_err) begin
            idx = int'(off >>> 2);
            if (we) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) model_mem[idx][8*i +: 8] = wdata[8*i +: 8];
            end else begin
                exp_rdata = model_mem[idx];
            end
        end
    endtask

    // Present one request to the main instance; returns #1 after the
    // acceptance edge.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        int t = 0;
        while (!req_ready && t < 50) begin @(posedge clk); #1; t++; end
        check("req_ready_before_issue", 32'(req_ready), 32'd1);
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        model_apply(we, addr, wdata, be);
    endtask

    // Wait for the response, check latency and payload, optionally stall the
    // core for 'hold' cycles (with an intruding request when 'poke' is set).
    task automatic complete(input int hold, input bit poke);
        int          n = 1;
        logic [31:0] rd_seen;
        logic        er_seen;
        resp_ready = (hold == 0);
        while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
        check("latency", 32'(n), 32'(c_main_lat));
        check("rdata", resp_rdata, exp_rdata);
        check("err", 32'(resp_err), 32'(exp_err));
        rd_seen = resp_rdata;
        er_seen = resp_err;
        for (int k = 0; k < hold; k++) begin
            if (poke && k == 0) begin
                req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hBAD0BAD0;
                req_be = 4'b1111; req_valid = 1'b1;
            end
            @(posedge clk); #1;
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_rdata", resp_rdata, rd_seen);
            check("hold_err", 32'(resp_err), 32'(er_seen));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("post_hs_valid", 32'(resp_valid), 32'd0);
        check("post_hs_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
    endtask

    function automatic logic aux_ready(input int which);
        return (which == 1) ? a1_req_ready : a7_req_ready;
    endfunction
    function automatic logic aux_valid(input int which);
        return (which == 1) ? a1_resp_valid : a7_resp_valid;
    endfunction

    task automatic aux_txn(input int which, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input int exp_lat, input logic x_err, input logic [31:0] x_rd);
        int t = 0;
        int n = 1;
        while (!aux_ready(which) && t < 50) begin @(posedge clk); #1; t++; end
        check("aux_req_ready", 32'(aux_ready(which)), 32'd1);
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        if (which == 1) a1_req_valid = 1'b1; else a7_req_valid = 1'b1;
        @(posedge clk); #1;
        a1_req_valid = 1'b0; a7_req_valid = 1'b0;
        while (!aux_valid(which) && n < 40) begin @(posedge clk); #1; n++; end
        check("aux_latency", 32'(n), 32'(exp_lat));
        check("aux_err", 32'((which == 1) ? a1_resp_err : a7_resp_err), 32'(x_err));
        check("aux_rdata", (which == 1) ? a1_resp_rdata : a7_resp_rdata, x_rd);
        @(posedge clk); #1;
        check("aux_post_hs", 32'(aux_valid(which)), 32'd0);
    endtask

    initial begin
        logic        r_we;
        logic [31:0] r_addr;
        logic [3:0]  r_be;
        int          r_idx;
        logic [3:0]  legal_tab [7];
        legal_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        rst = 1'b0;
        #1;
        check("rel_req_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("rel_req_ready_high", 32'(req_ready), 32'd1);

        // Give words 0..31 known contents
        for (int i = 0; i < 32; i++) begin
            issue(1'b1, 32'(i * 4), $urandom, 4'b1111);
            complete(0, 1'b0);
        end

        // Word round trip
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111); complete(0, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 4'b1111);        complete(0, 1'b0);
        check("roundtrip_model", exp_rdata, 32'hDEADBEEF);

        // Byte / half merge
        issue(1'b1, 32'h20, 32'h11223344, 4'b1111); complete(0, 1'b0);
        issue(1'b1, 32'h20, 32'h0000AA00, 4'b0010); complete(0, 1'b0);
        issue(1'b1, 32'h20, 32'h55660000, 4'b1100); complete(0, 1'b0);
        issue(1'b0, 32'h20, 32'h0, 4'b0001);        complete(0, 1'b0);
        check("merge_model", exp_rdata, 32'h5566AA44);

        // Errors: bad enables, out-of-range address, 0x30 untouched
        issue(1'b1, 32'h30, 32'hFFFFFFFF, 4'b0101); complete(0, 1'b0);
        issue(1'b1, 32'h30, 32'hFFFFFFFF, 4'b0000); complete(0, 1'b0);
        issue(1'b0, c_main_base + 32'(c_main_depth * 4), 32'h0, 4'b1111); complete(0, 1'b0);
        check("oob_model_err", 32'(exp_err), 32'd1);
        issue(1'b0, 32'h30, 32'h0, 4'b1111); complete(0, 1'b0);

        // Backpressure with an intruding request during the stall
        issue(1'b0, 32'h10, 32'h0, 4'b1111); complete(5, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 4'b1111); complete(0, 1'b0);

        // Latency sweep and address-window edges on the auxiliary instances
        aux_txn(1, 1'b1, 32'h8,   32'h12345678, 4'b1111, 1, 1'b0, 32'h0);
        aux_txn(1, 1'b0, 32'h8,   32'h0,        4'b1111, 1, 1'b0, 32'h12345678);
        aux_txn(1, 1'b0, 32'h40,  32'h0,        4'b1111, 1, 1'b1, 32'h0);
        aux_txn(7, 1'b1, 32'h104, 32'h0BADCAFE, 4'b1111, 7, 1'b0, 32'h0);
        aux_txn(7, 1'b0, 32'h104, 32'h0,        4'b1111, 7, 1'b0, 32'h0BADCAFE);
        aux_txn(7, 1'b0, 32'hFC,  32'h0,        4'b1111, 7, 1'b1, 32'h0);
        aux_txn(7, 1'b0, 32'h140, 32'h0,        4'b1111, 7, 1'b1, 32'h0);
        aux_txn(7, 1'b0, 32'h13C, 32'h0,        4'b1000, 7, 1'b0, a7_resp_rdata);

        // Async reset while a store waits
        issue(1'b1, 32'h40, 32'hCAFEF00D, 4'b1111);
        rst = 1'b1;
        #1;
        check("rst_wait_valid", 32'(resp_valid), 32'd0);
        check("rst_wait_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_wait_release_ready", 32'(req_ready), 32'd1);
        issue(1'b0, 32'h40, 32'h0, 4'b1111); complete(0, 1'b0);
        check("rst_store_persist_model", exp_rdata, 32'hCAFEF00D);

        // Async reset while a response is being presented
        issue(1'b0, 32'h40, 32'h0, 4'b1111);
        resp_ready = 1'b0;
        @(posedge clk); #1;
        check("resp_state_valid", 32'(resp_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_resp_drop_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_drop_rdata", resp_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_resp_release_ready", 32'(req_ready), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 150; i++) begin
            r_we  = 1'($urandom_range(0, 1));
            r_be  = ($urandom_range(0, 9) < 7) ? legal_tab[$urandom_range(0, 6)]
                                               : 4'($urandom_range(0, 15));
            r_idx = ($urandom_range(0, 9) == 0) ? c_main_depth + $urandom_range(0, 100)
                                                : $urandom_range(0, 31);
            r_addr = 32'(r_idx * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) r_addr = 32'hFFFF_FFF0;
            issue(r_we, r_addr, $urandom, r_be);
            complete($urandom_range(0, 3), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
